pc_sequencer: RTL



---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_return_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
// Holds the op encodings, default vectors and the sticky-flag helper.
package pc_pkg;

  typedef enum logic [1:0] {
    OP_INC    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_CALL   = 2'b10,
    OP_RET    = 2'b11
  } op_e;

  localparam int unsigned DEF_RESET_VECTOR = 0;
  localparam int unsigned DEF_TRAP_VECTOR  = 1023;

  // Sticky flag update: clear request drops the flag, a new event in the
  // same cycle takes priority and leaves it set.
  function automatic logic sticky_next(input logic flag, input logic clr,
                                       input logic set);
    return (flag & ~clr) | set;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO of return addresses with occupancy counter.
// A push while full and a pop while empty are ignored here; the caller
// turns those cases into error flags.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   top_idx;
  logic            do_push;
  logic            do_pop;

  assign full    = (sp == SP_MAX);
  assign empty   = (sp == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_idx  = sp[AW-1:0];
  // Top-of-stack index wraps correctly even when sp == DEPTH is a power of two.
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign pop_data = mem[top_idx];

  // Occupancy counter; push and pop never arrive together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage is data only: written on push, contents undefined after reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generation with branches and call/return stack.
// Optional build macro PC_STACK_TRAP_EN: stack errors redirect pc to
// TRAP_VECTOR instead of the normal destination.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          PC_W         = 10,
  parameter int          DEPTH        = 8,
  parameter int unsigned RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int unsigned TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic [1:0]                 op,
  input  logic                       abs_mode,
  input  logic [PC_W-1:0]            target,
  input  logic                       clr_err,
  output logic [PC_W-1:0]            pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VECTOR);

  if (DEPTH < 2) begin : g_bad_depth
    $error("pc_sequencer: DEPTH must be at least 2");
  end
  if ((RESET_VECTOR >> PC_W) != 0 || (TRAP_VECTOR >> PC_W) != 0) begin : g_bad_vec
    $error("pc_sequencer: vectors must fit in PC_W bits");
  end

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] pop_data;
  logic [PC_W-1:0] pc_next;
  logic            push;
  logic            pop;
  logic            ovf_evt;
  logic            unf_evt;

  // Relative targets rely on modulo-2^PC_W addition for two's complement.
  assign pc_inc  = pc + PC_W'(1);
  assign br_tgt  = abs_mode ? target : pc + target;
  assign push    = ~stall & (op == OP_CALL);
  assign pop     = ~stall & (op == OP_RET);
  assign ovf_evt = push & stack_full;
  assign unf_evt = pop & stack_empty;

  pc_return_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .SP_W  (SP_W)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .sp        (sp),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Next-pc selection by op, including the stack-error destinations.
  always_comb begin
    pc_next = pc_inc;
    case (op_e'(op))
      OP_INC:    pc_next = pc_inc;
      OP_BRANCH: pc_next = br_tgt;
`ifdef PC_STACK_TRAP_EN
      OP_CALL:   pc_next = stack_full ? PC_W'(TRAP_VECTOR) : br_tgt;
      OP_RET:    pc_next = stack_empty ? PC_W'(TRAP_VECTOR) : pop_data;
`else
      OP_CALL:   pc_next = br_tgt;
      OP_RET:    pc_next = stack_empty ? pc_inc : pop_data;
`endif
      default:   pc_next = pc_inc;
    endcase
  end

  // pc holds on stall; error flags still honour clr_err during a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!stall) begin
        pc <= pc_next;
      end
      overflow  <= sticky_next(overflow, clr_err, ovf_evt);
      underflow <= sticky_next(underflow, clr_err, unf_evt);
    end
  end

endmodule
